// File: rtl/mem_bus_target.sv
// Memory-bus responder: word RAM with byte/half/word access, post-reset clear, optional mtimer (MEM_BUS_TARGET_MTIMER_EN).
// Latency: mem_rdata and error pulses are registered and valid one cycle after the sampling edge.
// Backpressure: none; requests arriving while busy (clear sequence) are dropped.
module mem_bus_target #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter logic [31:0] MTIMER_BASE    = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [1:0]  mem_width,
    output logic [31:0] mem_rdata,
    output logic        busy,
    output logic        misalign_err,
    output logic        range_err,
    output logic        timer_irq
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

`ifdef MEM_BUS_TARGET_MTIMER_EN
    localparam logic TMR_EN = 1'b1;
`else
    localparam logic TMR_EN = 1'b0;
`endif

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             misalign_q, misalign_d;
    logic             range_q, range_d;

    logic [31:0]      mem_q [DEPTH];

    logic             idle;
    logic             req;
    logic             acc;
    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic             tmr_hit;
    logic             align_bad;
    logic             misalign_hit;
    logic             ram_ok;
    logic             tmr_ok;
    logic             ram_we;
    logic             clr_we;
    logic [3:0]       byte_en;
    logic [31:0]      wlane;
    logic [31:0]      rd_word;
    logic [31:0]      load_data;
    logic [31:0]      tmr_rdata;

    assign idle     = (state_q == ST_IDLE);
    assign req      = mem_read_en | mem_write_en;
    assign acc      = idle & req;
    assign word_idx = mem_addr[ADDR_WIDTH-1:2];
    assign in_range = (mem_addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
    assign tmr_hit  = TMR_EN & (mem_addr[31:4] == MTIMER_BASE[31:4]);

    always_comb begin
        align_bad = 1'b0;
        case (mem_width)
            2'd0:    align_bad = 1'b0;
            2'd1:    align_bad = mem_addr[0];
            2'd2:    align_bad = (mem_addr[1:0] != 2'b00);
            default: align_bad = 1'b1;
        endcase
    end

    // Timer registers are word-only, so narrower accesses there count as misaligned.
    assign misalign_hit = align_bad | (tmr_hit & (mem_width != 2'd2));
    assign ram_ok       = acc & ~misalign_hit & ~tmr_hit & in_range;
    assign tmr_ok       = acc & ~misalign_hit & tmr_hit;
    assign ram_we       = ram_ok & mem_write_en;
    assign clr_we       = (state_q == ST_CLEAR);

    always_comb begin
        byte_en = 4'b0000;
        wlane   = mem_wdata;
        case (mem_width)
            2'd0: begin
                byte_en = 4'b0001 << mem_addr[1:0];
                wlane   = {4{mem_wdata[7:0]}};
            end
            2'd1: begin
                byte_en = mem_addr[1] ? 4'b1100 : 4'b0011;
                wlane   = {2{mem_wdata[15:0]}};
            end
            2'd2: begin
                byte_en = 4'b1111;
                wlane   = mem_wdata;
            end
            default: begin
                byte_en = 4'b0000;
                wlane   = mem_wdata;
            end
        endcase
    end

    assign rd_word = mem_q[word_idx];

    always_comb begin
        load_data = rd_word;
        case (mem_width)
            2'd0:    load_data = {24'd0, rd_word[{mem_addr[1:0], 3'b000} +: 8]};
            2'd1:    load_data = {16'd0, rd_word[{mem_addr[1], 4'b0000} +: 16]};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        misalign_d = acc & misalign_hit;
        range_d    = acc & ~misalign_hit & ~tmr_hit & ~in_range;
        rdata_d    = rdata_q;
        if (!idle || misalign_d || range_d) begin
            rdata_d = '0;
        end else if (ram_ok && mem_read_en) begin
            rdata_d = load_data;
        end else if (tmr_ok && mem_read_en) begin
            rdata_d = tmr_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_idx_q  <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            range_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            range_q    <= range_d;
        end
    end

    // RAM array has no reset; the clear sequencer zero-fills it instead.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_idx_q] <= '0;
        end else if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

`ifdef MEM_BUS_TARGET_MTIMER_EN
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        irq_q;
    logic        tmr_we;

    assign tmr_we = tmr_ok & mem_write_en;

    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (tmr_we) begin
            case (mem_addr[3:2])
                2'd0:    mtime_d    = {mtime_q[63:32], mem_wdata};
                2'd1:    mtime_d    = {mem_wdata, mtime_q[31:0]};
                2'd2:    mtimecmp_d = {mtimecmp_q[63:32], mem_wdata};
                default: mtimecmp_d = {mem_wdata, mtimecmp_q[31:0]};
            endcase
        end
    end

    always_comb begin
        tmr_rdata = '0;
        case (mem_addr[3:2])
            2'd0:    tmr_rdata = mtime_q[31:0];
            2'd1:    tmr_rdata = mtime_q[63:32];
            2'd2:    tmr_rdata = mtimecmp_q[31:0];
            default: tmr_rdata = mtimecmp_q[63:32];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign timer_irq = irq_q;
`else
    assign tmr_rdata = '0;
    assign timer_irq = 1'b0;
`endif

    assign mem_rdata    = rdata_q;
    assign busy         = (state_q == ST_CLEAR);
    assign misalign_err = misalign_q;
    assign range_err    = range_q;

endmodule

// File: tb/tb_mem_bus_target.sv
// Bench for mem_bus_target (ADDR_WIDTH=6): directed steps plus random traffic against a byte-array model.
module tb_mem_bus_target;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [1:0]  mem_width;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        misalign_err;
    logic        range_err;
    logic        timer_irq;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  mdl [64];
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    mem_bus_target #(
        .ADDR_WIDTH    (6),
        .BASE_ADDR     (32'h0000_0000),
        .CLEAR_ON_RESET(1),
        .MTIMER_BASE   (32'hF000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_read_en (mem_read_en),
        .mem_write_en(mem_write_en),
        .mem_width   (mem_width),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .misalign_err(misalign_err),
        .range_err   (range_err),
        .timer_irq   (timer_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus request, sampled on exactly one posedge; returns 1 time unit after that edge.
    task automatic op(input logic rd, input logic wr, input logic [1:0] w,
                      input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_read_en  = rd;
        mem_write_en = wr;
        mem_width    = w;
        mem_addr     = a;
        mem_wdata    = d;
        @(posedge clk);
        #1;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
    endtask

    // Request checked against the byte-addressed little-endian model.
    task automatic txn(input logic rd, input logic wr, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d);
        logic        em;
        logic        er;
        logic        mis;
        int          nb;
        logic [31:0] v;
        em  = 1'b0;
        er  = 1'b0;
        mis = (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'b00);
        if (rd || wr) begin
            if (mis) begin
                em        = 1'b1;
                exp_rdata = 32'h0;
            end else if (a >= 32'd64) begin
                er        = 1'b1;
                exp_rdata = 32'h0;
            end else begin
                nb = 1 << w;
                if (rd) begin
                    v = 32'h0;
                    for (int i = 0; i < nb; i++) v = v | (32'(mdl[int'(a) + i]) << (8 * i));
                    exp_rdata = v;
                end
                if (wr) begin
                    for (int i = 0; i < nb; i++) mdl[int'(a) + i] = d[8*i +: 8];
                end
            end
        end
        op(rd, wr, w, a, d);
        chk("rdata", mem_rdata, exp_rdata);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, em});
        chk("range_err", {31'b0, range_err}, {31'b0, er});
    endtask

    initial begin
        int cnt;
        reset        = 1'b1;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_width    = 2'd0;
        exp_rdata    = 32'h0;
        model_zero();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
        chk("rst_range", {31'b0, range_err}, 32'd0);
        chk("rst_irq", {31'b0, timer_irq}, 32'd0);

        // First clear pass, with requests injected while busy.
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        op(1'b1, 1'b1, 2'd2, 32'h0, 32'hCAFE_F00D);
        chk("busy_rw_rdata", mem_rdata, 32'h0);
        chk("busy_mid", {31'b0, busy}, 32'd1);
        op(1'b1, 1'b0, 2'd3, 32'h1, 32'h0);
        chk("busy_no_misalign", {31'b0, misalign_err}, 32'd0);
        cnt = 6;
        while (busy && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("clear_len", 32'(cnt), 32'd16);

        txn(1'b1, 1'b0, 2'd2, 32'h0, 32'h0);
        chk("busy_write_ignored", mem_rdata, 32'h0);
        txn(1'b1, 1'b0, 2'd2, 32'h3C, 32'h0);
        chk("clear_word_3c", mem_rdata, 32'h0);

        txn(1'b0, 1'b1, 2'd2, 32'h8, 32'h1122_3344);
        txn(1'b0, 1'b1, 2'd0, 32'hA, 32'h0000_00AA);
        txn(1'b1, 1'b0, 2'd2, 32'h8, 32'h0);
        chk("merge_word", mem_rdata, 32'h11AA_3344);
        txn(1'b1, 1'b0, 2'd0, 32'hB, 32'h0);
        chk("byte_b", mem_rdata, 32'h0000_0011);
        txn(1'b1, 1'b0, 2'd1, 32'hA, 32'h0);
        chk("half_a", mem_rdata, 32'h0000_11AA);

        txn(1'b0, 1'b1, 2'd2, 32'h4, 32'h0BAD_F00D);
        txn(1'b0, 1'b1, 2'd1, 32'h5, 32'h0000_5555);
        chk("mis_half_pulse", {31'b0, misalign_err}, 32'd1);
        chk("mis_half_rdata", mem_rdata, 32'h0);
        @(posedge clk);
        #1;
        chk("mis_pulse_fall", {31'b0, misalign_err}, 32'd0);
        txn(1'b1, 1'b0, 2'd2, 32'h4, 32'h0);
        chk("mis_ram_unchanged", mem_rdata, 32'h0BAD_F00D);
        txn(1'b1, 1'b0, 2'd3, 32'h0, 32'h0);
        chk("width3_misalign", {31'b0, misalign_err}, 32'd1);

        txn(1'b1, 1'b0, 2'd2, 32'h8, 32'h0);
        txn(1'b1, 1'b0, 2'd2, 32'h1000, 32'h0);
        chk("range_pulse", {31'b0, range_err}, 32'd1);
        chk("range_rdata", mem_rdata, 32'h0);
        txn(1'b1, 1'b0, 2'd2, 32'h1002, 32'h0);
        chk("mis_over_range", {31'b0, range_err}, 32'd0);

        txn(1'b0, 1'b1, 2'd2, 32'h4, 32'hDEAD_BEEF);
        txn(1'b1, 1'b1, 2'd2, 32'h4, 32'h1234_5678);
        chk("rbw_old", mem_rdata, 32'hDEAD_BEEF);
        txn(1'b1, 1'b0, 2'd2, 32'h4, 32'h0);
        chk("rbw_new", mem_rdata, 32'h1234_5678);
        txn(1'b0, 1'b0, 2'd2, 32'h8, 32'h0);
        txn(1'b0, 1'b1, 2'd2, 32'h10, 32'h5A5A_A5A5);
        chk("rdata_hold", mem_rdata, 32'h1234_5678);

        for (int i = 0; i < 250; i++) begin
            txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                32'($urandom_range(0, 32'h5F)), $urandom);
        end

`ifdef MEM_BUS_TARGET_MTIMER_EN
        op(1'b0, 1'b1, 2'd2, 32'hF000_000C, 32'd1);
        op(1'b0, 1'b1, 2'd2, 32'hF000_0000, 32'd0);
        op(1'b0, 1'b1, 2'd2, 32'hF000_0004, 32'd0);
        cnt = 0;
        op(1'b0, 1'b1, 2'd2, 32'hF000_0008, 32'd20);
        cnt++;
        op(1'b0, 1'b1, 2'd2, 32'hF000_000C, 32'd0);
        cnt++;
        chk("irq_low_before", {31'b0, timer_irq}, 32'd0);
        while (!timer_irq && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("irq_rise_cycle", 32'(cnt), 32'd21);
        op(1'b0, 1'b1, 2'd2, 32'hF000_000C, 32'd1);
        chk("irq_still_high", {31'b0, timer_irq}, 32'd1);
        @(posedge clk);
        #1;
        chk("irq_fall", {31'b0, timer_irq}, 32'd0);
        op(1'b1, 1'b0, 2'd0, 32'hF000_0000, 32'h0);
        chk("tmr_byte_misalign", {31'b0, misalign_err}, 32'd1);
        op(1'b1, 1'b0, 2'd2, 32'hF000_000C, 32'h0);
        chk("tmr_cmp_hi_read", mem_rdata, 32'd1);
        exp_rdata = mem_rdata;
`else
        op(1'b1, 1'b0, 2'd2, 32'hF000_0000, 32'h0);
        chk("tmr_off_range", {31'b0, range_err}, 32'd1);
        chk("tmr_off_irq", {31'b0, timer_irq}, 32'd0);
        exp_rdata = 32'h0;
`endif

        // Reset at clear index 7 must restart the full clear.
        txn(1'b0, 1'b1, 2'd2, 32'h3C, 32'hFFFF_FFFF);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midclr_busy", {31'b0, busy}, 32'd1);
        chk("midclr_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("midclr_len", 32'(cnt), 32'd16);
        model_zero();
        exp_rdata = 32'h0;
        txn(1'b1, 1'b0, 2'd2, 32'h3C, 32'h0);
        chk("midclr_word_3c", mem_rdata, 32'h0);
        txn(1'b1, 1'b0, 2'd2, 32'h4, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
